cpu_core: RTL and testbench
===========================

// Module: cpu_core
// PURPOSE
//  Microprogrammed Mic-1-style datapath driven by an external 28-bit microinstruction (mir).
//  It holds a register file, a 6-bit-controlled ALU with shifter, and an internal 16x32 RAM.
//  Each microinstruction executes over three clock cycles: memory read, then C-bus writeback,
//  then memory write. The B bus, C bus and RAM values are exported for observation.
// PARAMETERS
//  DATA_W   32   datapath width
//  ADDR_W   4    RAM address width (16 words)
// PORTS
//  clock          in   1   single clock, rising-edge
//  reset_n        in   1   asynchronous, active-low reset
//  mir            in   28  microinstruction, held stable for a full 3-cycle step
//  out_c          out  32  C bus (shifter output), combinational
//  out_b          out  32  B bus, combinational
//  out_ram_read   out  32  RAM[mir[17:14]], combinational read
//  out_ram_write  out  32  RAM write data (= MAR), combinational
// BEHAVIOUR
//  mir fields:
//   - [27:26] shift: 00 none, 10 SLL8, 01 SRA1, 11 none.
//   - [25:20] ALU F0 F1 ENA ENB INVA INC.
//   - [19:18] mem: 10 write, 01 read, 00/11 none.
//   - [17:14] RAM address.
//   - [13:4] C enables, bit13..4: H OPC TOS CPP LV SP PC MBR MDR MAR.
//   - [3:0] B select.
//  B select: 1 MDR, 2 PC, 3 MBR sign-ext, 4 MBR zero-ext, 5 SP, 6 LV, 7 CPP, 8 TOS, 9 OPC, else 0.
//  ALU operands:
//   - A = ENA ? H : 0, then inverted if INVA.
//   - B = ENB ? Bbus : 0.
//  ALU function (F0F1): 00 A&B; 01 A|B; 10 ~B; 11 A+B+INC, mod 2^32, no carry out.
//  The shifter applies to the ALU result. SRA1 is arithmetic.
//  Phase counter cycles 0->1->2->0, advancing on every rising clock edge.
//  Phase 0 edge: if mem==01, MDR <= RAM[addr].
//  Phase 1 edge: each register with its C enable set loads the C bus. MBR (8-bit) loads C[7:0].
//   - Exception: when mem==01, the MDR enable is ignored, so the read data is kept.
//  Phase 2 edge: if mem==10, RAM[addr] <= MAR, using the MAR value just updated in phase 1.
//  The C bus is recomputed combinationally, so it reflects register values after phase 1.
//  reset_n low, asynchronously:
//   - phase <= 0.
//   - All registers (H OPC TOS CPP LV SP PC MBR MDR MAR) <= 0.
//   - All 16 RAM words <= 0.
//  Outputs are combinational, so at reset they evaluate from zeroed state.
//  Reset asserted mid-step aborts the step. Execution restarts at phase 0 on the first edge
//  after release.
//  mem==11 performs neither a read nor a write.
// STRUCTURE
//  Shared package cpu_pkg:
//   - mir field bit-position constants.
//   - B-select codes and C-enable bit indices.
//   - ALU function and shift encodings.
//  One sub-module, cpu_alu: combinational ALU plus shifter (F0..INC, shift -> C).
//  Registers, RAM, phase counter and bus mux live in cpu_core.
// TESTING
//  Apply reset, then each step holds mir for 3 clocks; outputs are checked after the third.
//  1. mir=00_110001_10_0001_0000001101_0000:
//     -> MAR=PC=MBR=1, RAM[1]=1, out_c=1, out_ram_read=1, out_ram_write=1.
//  2. mir=00_110101_01_0001_1000001111_0001:
//     -> MDR=1, out_b=1, out_c=2, H=MAR=2, out_ram_read=1, out_ram_write=2.
//  3. mir=00_000000_10_0010_0000001100_0000:
//     -> RAM[2]=2, out_ram_read=2, out_c=0.
//  4. mir=00_111100_00_0000_0000000001_0001:
//     -> out_b=1, out_c=3 (H+MDR), MAR=3, out_ram_write=3.
//  5. mir=00_000000_10_0011_0000001100_0000:
//     -> RAM[3]=3, out_ram_read=3.
//  6. Load H=0x80000000, then run shift 01 on ENA pass:
//     -> out_c=0xC0000000; shift 10 on H=1 -> out_c=0x100.
//     Assert reset_n mid-step -> all outputs and registers 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the microprogrammed datapath: mir field positions, bus select
// codes, C-enable bit indices, ALU/shift/memory operation codes and step phases.
package cpu_pkg;

  localparam int unsigned MIR_W = 28;

  // mir field bit positions
  localparam int unsigned SHIFT_HI = 27;
  localparam int unsigned SHIFT_LO = 26;
  localparam int unsigned ALU_F0   = 25;
  localparam int unsigned ALU_F1   = 24;
  localparam int unsigned ALU_ENA  = 23;
  localparam int unsigned ALU_ENB  = 22;
  localparam int unsigned ALU_INVA = 21;
  localparam int unsigned ALU_INC  = 20;
  localparam int unsigned MEM_HI   = 19;
  localparam int unsigned MEM_LO   = 18;
  localparam int unsigned ADDR_LO  = 14;
  localparam int unsigned C_HI     = 13;
  localparam int unsigned C_LO     = 4;
  localparam int unsigned B_HI     = 3;
  localparam int unsigned B_LO     = 0;

  // Bit indices inside the 10-bit C-enable field (mir[13:4])
  localparam int unsigned C_MAR = 0;
  localparam int unsigned C_MDR = 1;
  localparam int unsigned C_MBR = 2;
  localparam int unsigned C_PC  = 3;
  localparam int unsigned C_SP  = 4;
  localparam int unsigned C_LV  = 5;
  localparam int unsigned C_CPP = 6;
  localparam int unsigned C_TOS = 7;
  localparam int unsigned C_OPC = 8;
  localparam int unsigned C_H   = 9;

  // B bus source select
  localparam logic [3:0] B_MDR  = 4'd1;
  localparam logic [3:0] B_PC   = 4'd2;
  localparam logic [3:0] B_MBRS = 4'd3;
  localparam logic [3:0] B_MBRU = 4'd4;
  localparam logic [3:0] B_SP   = 4'd5;
  localparam logic [3:0] B_LV   = 4'd6;
  localparam logic [3:0] B_CPP  = 4'd7;
  localparam logic [3:0] B_TOS  = 4'd8;
  localparam logic [3:0] B_OPC  = 4'd9;

  // ALU function {F0,F1}
  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_NOTB = 2'b10;
  localparam logic [1:0] FN_ADD  = 2'b11;

  // Shifter control
  localparam logic [1:0] SH_SRA1 = 2'b01;
  localparam logic [1:0] SH_SLL8 = 2'b10;

  // Memory operation
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Step phases
  localparam logic [1:0] PH_READ  = 2'd0;
  localparam logic [1:0] PH_WB    = 2'd1;
  localparam logic [1:0] PH_WRITE = 2'd2;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU followed by the shifter; produces the C bus from H and the B bus.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        fn,
  input  logic              ena,
  input  logic              enb,
  input  logic              inva,
  input  logic              inc,
  input  logic [1:0]        shift,
  input  logic [DATA_W-1:0] h,
  input  logic [DATA_W-1:0] b_bus,
  output logic [DATA_W-1:0] c_bus
);

  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] alu_out;

  always_comb begin
    a_op = ena ? h : '0;
    if (inva) a_op = ~a_op;
    b_op = enb ? b_bus : '0;
    unique case (fn)
      FN_AND:  alu_out = a_op & b_op;
      FN_OR:   alu_out = a_op | b_op;
      FN_NOTB: alu_out = ~b_op;
      default: alu_out = a_op + b_op + {{(DATA_W-1){1'b0}}, inc};
    endcase
  end

  always_comb begin
    case (shift)
      SH_SLL8: c_bus = {alu_out[DATA_W-9:0], 8'h00};
      SH_SRA1: c_bus = {alu_out[DATA_W-1], alu_out[DATA_W-1:1]};
      default: c_bus = alu_out;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Mic-1-style datapath: register file, B-bus mux, internal RAM and a 3-phase step
// sequencer (memory read, C-bus writeback, memory write) driven by an external mir.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [MIR_W-1:0]  mir,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_ram_read,
  output logic [DATA_W-1:0] out_ram_write
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  logic [1:0]        phase;
  logic [DATA_W-1:0] h, opc, tos, cpp, lv, sp, pc, mdr, mar;
  logic [7:0]        mbr;
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [1:0]        mem;
  logic [ADDR_W-1:0] addr;
  logic [9:0]        c_en;
  logic [3:0]        b_sel;
  logic [DATA_W-1:0] b_bus;
  logic [DATA_W-1:0] c_bus;

  assign mem   = mir[MEM_HI:MEM_LO];
  assign addr  = mir[ADDR_LO +: ADDR_W];
  assign c_en  = mir[C_HI:C_LO];
  assign b_sel = mir[B_HI:B_LO];

  always_comb begin
    case (b_sel)
      B_MDR:   b_bus = mdr;
      B_PC:    b_bus = pc;
      B_MBRS:  b_bus = {{(DATA_W-8){mbr[7]}}, mbr};
      B_MBRU:  b_bus = {{(DATA_W-8){1'b0}}, mbr};
      B_SP:    b_bus = sp;
      B_LV:    b_bus = lv;
      B_CPP:   b_bus = cpp;
      B_TOS:   b_bus = tos;
      B_OPC:   b_bus = opc;
      default: b_bus = '0;
    endcase
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .fn    (mir[ALU_F0:ALU_F1]),
    .ena   (mir[ALU_ENA]),
    .enb   (mir[ALU_ENB]),
    .inva  (mir[ALU_INVA]),
    .inc   (mir[ALU_INC]),
    .shift (mir[SHIFT_HI:SHIFT_LO]),
    .h     (h),
    .b_bus (b_bus),
    .c_bus (c_bus)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH_READ;
      h     <= '0;
      opc   <= '0;
      tos   <= '0;
      cpp   <= '0;
      lv    <= '0;
      sp    <= '0;
      pc    <= '0;
      mbr   <= '0;
      mdr   <= '0;
      mar   <= '0;
      for (int unsigned i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
    end else begin
      case (phase)
        PH_READ: begin
          if (mem == MEM_READ) mdr <= ram[addr];
          phase <= PH_WB;
        end
        PH_WB: begin
          if (c_en[C_H])   h   <= c_bus;
          if (c_en[C_OPC]) opc <= c_bus;
          if (c_en[C_TOS]) tos <= c_bus;
          if (c_en[C_CPP]) cpp <= c_bus;
          if (c_en[C_LV])  lv  <= c_bus;
          if (c_en[C_SP])  sp  <= c_bus;
          if (c_en[C_PC])  pc  <= c_bus;
          if (c_en[C_MBR]) mbr <= c_bus[7:0];
          // A read in progress owns MDR; the C-bus enable must not clobber the fetched word.
          if (c_en[C_MDR] && mem != MEM_READ) mdr <= c_bus;
          if (c_en[C_MAR]) mar <= c_bus;
          phase <= PH_WRITE;
        end
        PH_WRITE: begin
          if (mem == MEM_WRITE) ram[addr] <= mar;
          phase <= PH_READ;
        end
        default: phase <= PH_READ;
      endcase
    end
  end

  assign out_c         = c_bus;
  assign out_b         = b_bus;
  assign out_ram_read  = ram[addr];
  assign out_ram_write = mar;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed microinstruction steps plus random steps
// compared against a behavioural model of one whole microinstruction.
module tb_cpu_core;

  logic        clock;
  logic        reset_n;
  logic [27:0] mir;
  logic [31:0] out_c, out_b, out_ram_read, out_ram_write;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_h, m_opc, m_tos, m_cpp, m_lv, m_sp, m_pc, m_mdr, m_mar;
  logic [7:0]  m_mbr;
  logic [31:0] m_ram [16];

  cpu_core #(
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mir           (mir),
    .out_c         (out_c),
    .out_b         (out_b),
    .out_ram_read  (out_ram_read),
    .out_ram_write (out_ram_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_opc = 0; m_tos = 0; m_cpp = 0; m_lv = 0;
    m_sp = 0; m_pc = 0; m_mdr = 0; m_mar = 0; m_mbr = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
  endtask

  function automatic logic [31:0] m_bbus(input logic [3:0] s);
    case (s)
      4'd1: return m_mdr;
      4'd2: return m_pc;
      4'd3: return {{24{m_mbr[7]}}, m_mbr};
      4'd4: return {24'h0, m_mbr};
      4'd5: return m_sp;
      4'd6: return m_lv;
      4'd7: return m_cpp;
      4'd8: return m_tos;
      4'd9: return m_opc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_cbus(input logic [27:0] m);
    logic [31:0] a, b, r;
    a = m[23] ? m_h : 32'h0;
    if (m[21]) a = ~a;
    b = m[22] ? m_bbus(m[3:0]) : 32'h0;
    case (m[25:24])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~b;
      default: r = a + b + {31'h0, m[20]};
    endcase
    if (m[27:26] == 2'b10) r = r << 8;
    else if (m[27:26] == 2'b01) r = $signed(r) >>> 1;
    return r;
  endfunction

  // Whole-microinstruction effect: read, then writeback, then write using the new MAR
  task automatic model_step(input logic [27:0] m);
    logic [3:0]  a;
    logic [9:0]  en;
    logic [31:0] c;
    a  = m[17:14];
    en = m[13:4];
    if (m[19:18] == 2'b01) m_mdr = m_ram[a];
    c = m_cbus(m);
    if (en[9]) m_h   = c;
    if (en[8]) m_opc = c;
    if (en[7]) m_tos = c;
    if (en[6]) m_cpp = c;
    if (en[5]) m_lv  = c;
    if (en[4]) m_sp  = c;
    if (en[3]) m_pc  = c;
    if (en[2]) m_mbr = c[7:0];
    if (en[1] && m[19:18] != 2'b01) m_mdr = c;
    if (en[0]) m_mar = c;
    if (m[19:18] == 2'b10) m_ram[a] = m_mar;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_c"}, out_c, m_cbus(mir));
    check({tag, ".out_b"}, out_b, m_bbus(mir[3:0]));
    check({tag, ".ram_rd"}, out_ram_read, m_ram[mir[17:14]]);
    check({tag, ".ram_wr"}, out_ram_write, m_mar);
  endtask

  // Drive at negedge, run the three phase edges, land on the following negedge
  task automatic run_step(input logic [27:0] m, input string tag);
    mir = m;
    repeat (3) @(posedge clock);
    @(negedge clock);
    model_step(m);
    check_outputs(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    mir     = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");
    check("reset.h", dut.h, 32'h0);
    reset_n = 1'b1;

    run_step(28'b00_110001_10_0001_0000001101_0000, "t1");
    check("t1.out_c", out_c, 32'd1);
    check("t1.pc", dut.pc, 32'd1);
    check("t1.mbr", {24'h0, dut.mbr}, 32'd1);
    check("t1.ram_rd", out_ram_read, 32'd1);

    run_step(28'b00_110101_01_0001_1000001111_0001, "t2");
    check("t2.mdr", dut.mdr, 32'd1);
    check("t2.out_b", out_b, 32'd1);
    check("t2.out_c", out_c, 32'd2);
    check("t2.h", dut.h, 32'd2);
    check("t2.ram_wr", out_ram_write, 32'd2);

    run_step(28'b00_000000_10_0010_0000001100_0000, "t3");
    check("t3.ram_rd", out_ram_read, 32'd2);
    check("t3.out_c", out_c, 32'd0);

    run_step(28'b00_111100_00_0000_0000000001_0001, "t4");
    check("t4.out_c", out_c, 32'd3);
    check("t4.ram_wr", out_ram_write, 32'd3);

    run_step(28'b00_000000_10_0011_0000001100_0000, "t5");
    check("t5.ram_rd", out_ram_read, 32'd3);

    // mem==11: neither read nor write
    run_step(28'b00_110001_11_0011_0000000011_0000, "mem11");
    check("mem11.ram_rd", out_ram_read, 32'd3);

    for (int i = 0; i < 40; i++) run_step(28'($urandom()), "rand");

    // Build H=0x80000000 by doubling H and MDR together
    run_step(28'b00_110001_00_0000_1000000010_0000, "h1");
    for (int i = 0; i < 31; i++) run_step(28'b00_111100_00_0000_1000000010_0001, "dbl");
    check("dbl.h", dut.h, 32'h8000_0000);
    mir = 28'b01_011000_00_0000_0000000000_0000;
    #1;
    check("sra1", out_c, 32'hC000_0000);
    check("sra1.model", out_c, m_cbus(mir));

    run_step(28'b00_110001_00_0000_1000000000_0000, "h1b");
    mir = 28'b10_011000_00_0000_0000000000_0000;
    #1;
    check("sll8", out_c, 32'h0000_0100);

    // Reset in the middle of a step
    @(negedge clock);
    mir = 28'b00_011000_10_0001_1000000001_0001;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mrst.out_c", out_c, 32'h0);
    check("mrst.out_b", out_b, 32'h0);
    check("mrst.ram_rd", out_ram_read, 32'h0);
    check("mrst.ram_wr", out_ram_write, 32'h0);
    check("mrst.h", dut.h, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_step(28'b00_110001_10_0001_0000000001_0000, "post");
    check("post.ram_rd", out_ram_read, 32'd1);
    for (int i = 0; i < 10; i++) run_step(28'($urandom()), "rand2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
